// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// state encoding, RV32I opcode classes and trap cause codes.
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_IMEM_TO = 2'b01,
        CAUSE_DMEM_TO = 2'b10,
        CAUSE_ILLEGAL = 2'b11
    } trap_cause_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ALUI, OP_ALUR, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-ready wait counter shared by the FETCH and MEM phases; flags the
// cycle in which the wait limit is reached with the request still unanswered.
module wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : W'(MEM_TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires on the cycle that would bring the count to MEM_TIMEOUT; a ready in
    // that same cycle drops en and therefore wins.
    assign expired = (MEM_TIMEOUT != 0) && en && (r_cnt == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the instruction
// register, gates PC/regfile/dmem updates and tracks cycle/retire counts.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             trapped,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    seq_state_t       r_state;
    trap_cause_t      r_cause;
    logic [31:0]      r_ir;
    logic             r_fetch_pend;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_is_store;
    logic             w_is_mem;
    logic             w_no_rd;
    logic             w_wait_clr;
    logic             w_wait_en;
    logic             w_expired;

    assign w_is_store = (r_ir[6:0] == OP_STORE);
    assign w_is_mem   = (r_ir[6:0] == OP_LOAD) || w_is_store;
    assign w_no_rd    = w_is_store || (r_ir[6:0] == OP_BRANCH);

    // Once a fetch is issued it is held regardless of run until ready.
    assign w_imem_req = (r_state == FETCH) && (run || r_fetch_pend);
    assign w_dmem_req = (r_state == MEM);

    assign w_wait_clr = (r_state != FETCH) && (r_state != MEM);
    assign w_wait_en  = (w_imem_req && !imem_ready) || (w_dmem_req && !dmem_ready);

    wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wait_clr),
        .en      (w_wait_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FETCH;
            r_cause       <= CAUSE_NONE;
            r_ir          <= NOP_INSTR;
            r_fetch_pend  <= 1'b0;
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            unique case (r_state)
                FETCH: begin
                    if (w_imem_req) begin
                        if (imem_ready) begin
                            r_ir         <= imem_rdata;
                            r_fetch_pend <= 1'b0;
                            r_state      <= DECODE;
                        end else if (w_expired) begin
                            r_fetch_pend <= 1'b0;
                            r_cause      <= CAUSE_IMEM_TO;
                            r_state      <= TRAP;
                        end else begin
                            r_fetch_pend <= 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (is_legal_opcode(r_ir[6:0])) begin
                        r_state <= EXEC;
                    end else begin
                        r_cause <= CAUSE_ILLEGAL;
                        r_state <= TRAP;
                    end
                end
                EXEC: begin
                    r_state <= w_is_mem ? MEM : WB;
                end
                MEM: begin
                    if (dmem_ready) begin
                        r_state <= WB;
                    end else if (w_expired) begin
                        r_cause <= CAUSE_DMEM_TO;
                        r_state <= TRAP;
                    end
                end
                WB: begin
                    r_instret_cnt <= r_instret_cnt + 1'b1;
                    r_state       <= FETCH;
                end
                TRAP: begin
                    r_state <= TRAP;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = w_imem_req;
    assign dmem_req    = w_dmem_req;
    assign dmem_we     = w_dmem_req && w_is_store;
    assign pc_we       = (r_state == WB);
    assign reg_we      = (r_state == WB) && !w_no_rd;
    assign ir          = r_ir;
    assign state       = r_state;
    assign trapped     = (r_state == TRAP);
    assign trap_cause  = r_cause;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a per-instruction timeline model predicts
// every cycle's outputs, plus literal pins on counters, pulses and trap state.
module tb_instr_sequencer;

    localparam int unsigned TO = 4;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    logic        clk = 1'b0;
    logic        rst, run, imem_ready, dmem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we, pc_we, reg_we, trapped;
    logic [31:0] ir, cycle_cnt, instret_cnt;
    logic [2:0]  state;
    logic [1:0]  trap_cause;

    instr_sequencer #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .reg_we      (reg_we),
        .state       (state),
        .trapped     (trapped),
        .trap_cause  (trap_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, dwe, pcwe, rwe;
    } exp_t;

    int          n_checks = 0, n_errors = 0;
    logic [31:0] m_cycle, m_instret, m_ir;
    logic        m_trapped;
    logic [1:0]  m_cause;
    int          pc_pulses, reg_pulses, dreq_cycles, dwe_cycles;
    int          last_pc_cycle, last_reg_cycle;

    function automatic exp_t mk(input logic [2:0] st, input logic ireq, input logic dreq,
                                input logic dwe, input logic pcwe, input logic rwe);
        exp_t e;
        e.st = st; e.ireq = ireq; e.dreq = dreq; e.dwe = dwe; e.pcwe = pcwe; e.rwe = rwe;
        return e;
    endfunction

    function automatic logic legal(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cycle = 0; m_instret = 0; m_ir = 32'h0000_0013; m_trapped = 1'b0; m_cause = 2'b00;
    endtask

    task automatic clear_stats();
        pc_pulses = 0; reg_pulses = 0; dreq_cycles = 0; dwe_cycles = 0;
        last_pc_cycle = 0; last_reg_cycle = 0;
    endtask

    // One clock cycle: drive inputs, compare every output at negedge, advance the model.
    task automatic cyc(input logic r, input logic run_v, input logic ir_v,
                       input logic [31:0] rd_v, input logic dr_v, input exp_t e);
        rst = r; run = run_v; imem_ready = ir_v; imem_rdata = rd_v; dmem_ready = dr_v;
        @(negedge clk);
        chk("state",       32'(state),      32'(e.st));
        chk("imem_req",    32'(imem_req),   32'(e.ireq));
        chk("dmem_req",    32'(dmem_req),   32'(e.dreq));
        chk("dmem_we",     32'(dmem_we),    32'(e.dwe));
        chk("pc_we",       32'(pc_we),      32'(e.pcwe));
        chk("reg_we",      32'(reg_we),     32'(e.rwe));
        chk("trapped",     32'(trapped),    32'(m_trapped));
        chk("trap_cause",  32'(trap_cause), 32'(m_cause));
        chk("ir",          ir,              m_ir);
        chk("cycle_cnt",   cycle_cnt,       m_cycle);
        chk("instret_cnt", instret_cnt,     m_instret);
        if (pc_we === 1'b1)    begin pc_pulses++;  last_pc_cycle  = int'(m_cycle) + 1; end
        if (reg_we === 1'b1)   begin reg_pulses++; last_reg_cycle = int'(m_cycle) + 1; end
        if (dmem_req === 1'b1) dreq_cycles++;
        if (dmem_we === 1'b1)  dwe_cycles++;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (e.st != S_T) m_cycle++;
    endtask

    // Whole instruction: fetch after iwait stall cycles, optional dmem stall,
    // optional reset injected at fetch/mem cycle index; noise on unused readies.
    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input int rst_f, input int rst_m, input logic drop_run);
        logic st_mem, st_store, wr;
        logic rdy;
        st_store = (instr[6:0] == 7'h23);
        st_mem   = st_store || (instr[6:0] == 7'h03);
        wr       = !(st_store || instr[6:0] == 7'h63);
        for (int k = 0; k < 64; k++) begin
            rdy = (k == iwait);
            cyc(k == rst_f, (k == 0) || !drop_run, rdy, rdy ? instr : 32'hDEAD_BEEF, 1'b1,
                mk(S_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            if (k == rst_f) return;
            if (rdy) begin m_ir = instr; break; end
            if (k == TO - 1) begin m_trapped = 1'b1; m_cause = 2'b01; return; end
        end
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, mk(S_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (!legal(instr)) begin m_trapped = 1'b1; m_cause = 2'b11; return; end
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, mk(S_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (st_mem) begin
            for (int k = 0; k < 64; k++) begin
                rdy = (k == dwait);
                cyc(k == rst_m, 1'b0, 1'b1, 32'hFFFF_FFFF, rdy,
                    mk(S_M, 1'b0, 1'b1, st_store, 1'b0, 1'b0));
                if (k == rst_m) return;
                if (rdy) break;
                if (k == TO - 1) begin m_trapped = 1'b1; m_cause = 2'b10; return; end
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, mk(S_W, 1'b0, 1'b0, 1'b0, 1'b1, wr));
        m_instret++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, mk(S_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic trap_cycles(input int n);
        for (int k = 0; k < n; k++)
            cyc(1'b0, 1'b1, (k % 2) == 1, 32'h0000_0093, 1'b1, mk(S_T, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, mk(m_trapped ? S_T : S_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] misc [5];
        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_stats();

        chk("rst_state",   32'(state),      32'd0);
        chk("rst_ir",      ir,              32'h0000_0013);
        chk("rst_cycle",   cycle_cnt,       32'd0);
        chk("rst_instret", instret_cnt,     32'd0);
        chk("rst_trapped", 32'(trapped),    32'd0);
        chk("rst_cause",   32'(trap_cause), 32'd0);
        chk("rst_strobes", {27'd0, imem_req, dmem_req, dmem_we, pc_we, reg_we}, 32'd0);

        // ADDI, zero-wait
        run_instr(32'h0050_0093, 0, 0, -1, -1, 1'b0);
        chk("addi_cycle",   cycle_cnt,   32'd4);
        chk("addi_instret", instret_cnt, 32'd1);
        chk("addi_ir",      ir,          32'h0050_0093);
        chk("addi_pc_at",   32'(last_pc_cycle),  32'd4);
        chk("addi_reg_at",  32'(last_reg_cycle), 32'd4);

        // LW with 3 dmem wait cycles (ready lands on the would-be timeout cycle)
        clear_stats();
        run_instr(32'h0000_A103, 0, 3, -1, -1, 1'b0);
        chk("lw_dreq_cycles", 32'(dreq_cycles),   32'd4);
        chk("lw_dwe_cycles",  32'(dwe_cycles),    32'd0);
        chk("lw_reg_at",      32'(last_reg_cycle), 32'd12);
        chk("lw_cycle",       cycle_cnt,           32'd12);

        // SW (one fetch stall with run dropped) then BEQ
        clear_stats();
        run_instr(32'h0020_A023, 1, 0, -1, -1, 1'b1);
        run_instr(32'h0000_0063, 0, 0, -1, -1, 1'b0);
        chk("swbeq_pc_pulses",  32'(pc_pulses),  32'd2);
        chk("swbeq_reg_pulses", 32'(reg_pulses), 32'd0);
        chk("swbeq_dwe_cycles", 32'(dwe_cycles), 32'd1);
        chk("swbeq_instret",    instret_cnt,     32'd4);
        chk("swbeq_cycle",      cycle_cnt,       32'd22);

        idle(6);

        // Reset while a load is waiting in MEM
        run_instr(32'h0000_A103, 0, 5, -1, 1, 1'b0);
        chk("rstmem_state",   32'(state),    32'd0);
        chk("rstmem_dreq",    32'(dmem_req), 32'd0);
        chk("rstmem_cycle",   cycle_cnt,     32'd0);
        chk("rstmem_instret", instret_cnt,   32'd0);
        chk("rstmem_ir",      ir,            32'h0000_0013);

        // Illegal opcode
        run_instr(32'h0000_0000, 0, 0, -1, -1, 1'b0);
        trap_cycles(4);
        chk("ill_state", 32'(state),      32'd5);
        chk("ill_cause", 32'(trap_cause), 32'd3);
        chk("ill_cycle", cycle_cnt,       32'd2);
        chk("ill_ir",    ir,              32'h0000_0000);
        do_reset();

        // Fetch timeout: ready never comes, run dropped after the first request cycle
        run_instr(32'h0050_0093, 99, 0, -1, -1, 1'b1);
        trap_cycles(2);
        chk("ito_cause",   32'(trap_cause), 32'd1);
        chk("ito_trapped", 32'(trapped),    32'd1);
        chk("ito_cycle",   cycle_cnt,       32'd4);
        do_reset();

        // Fetch ready on the 4th request cycle: no trap
        run_instr(32'h0050_0093, 3, 0, -1, -1, 1'b0);
        chk("irdy4_trapped", 32'(trapped), 32'd0);
        chk("irdy4_instret", instret_cnt,  32'd1);
        chk("irdy4_cycle",   cycle_cnt,    32'd7);

        // Reset coinciding with a fetch timeout: reset wins
        run_instr(32'h0050_0093, 99, 0, 3, -1, 1'b0);
        chk("rstto_trapped", 32'(trapped), 32'd0);
        chk("rstto_state",   32'(state),   32'd0);

        // Data-memory timeout on a store
        idle(1);
        run_instr(32'h0020_A023, 0, 99, -1, -1, 1'b0);
        trap_cycles(1);
        chk("dto_cause", 32'(trap_cause), 32'd2);
        chk("dto_cycle", cycle_cnt,       32'd8);
        do_reset();

        // Remaining classes with varied fetch stalls
        misc[0] = 32'h0000_006F; misc[1] = 32'h0000_8067; misc[2] = 32'h0000_12B7;
        misc[3] = 32'h0000_1297; misc[4] = 32'h0020_81B3;
        clear_stats();
        for (int i = 0; i < 5; i++) run_instr(misc[i], i % 3, 0, -1, -1, 1'b1);
        chk("misc_instret",    instret_cnt,     32'd5);
        chk("misc_cycle",      cycle_cnt,       32'd24);
        chk("misc_reg_pulses", 32'(reg_pulses), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
